key_event_queue: RTL and testbench

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

---
 rtl/key_event_queue.sv | 198 +++++++++++++++++++
 tb/tb_key_event_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/key_event_queue.sv
// key_event_queue
//
// Purpose: turns a held-key indication from a keyboard decoder into discrete
// key events and queues them for a consumer. A press event is generated when
// a key goes down (or when the held key's code changes). While the key stays
// down, auto-repeat events follow: the first one REPEAT_DELAY cycles after the
// press, then one every REPEAT_RATE cycles. Events land in a DEPTH-entry FIFO
// with show-ahead output.
//
// Ports:
//   i_clk        sole clock, rising edge
//   i_rst        asynchronous, active-high reset
//   i_key_ascii  ASCII code from the decoder (0x00 means "no key" and is ignored)
//   i_key_state  1 while the key is held
//   i_rd_en      consumer pop request
//   o_key        head-of-queue code, 0 when the queue is empty
//   o_valid      queue non-empty
//   o_full       count == DEPTH
//   o_count      number of stored entries
//   o_overflow   sticky: at least one event was dropped because the queue was full
//
// Handshake: o_valid/i_rd_en act as valid/ready. An entry is consumed on a
// rising edge where both o_valid and i_rd_en are 1; i_rd_en with o_valid low
// has no effect. o_key is stable while o_valid is high and no pop occurs.
module key_event_queue #(
  parameter int DEPTH        = 8,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_key_ascii,
  input  logic                     i_key_state,
  input  logic                     i_rd_en,
  output logic [7:0]               o_key,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Sample stage plus one cycle of history for edge/change detection.
  // The *_vld bits track how many samples have been taken since reset: a press
  // needs two valid samples, so a key that is already held when reset is
  // released is treated as old news and produces nothing until it is released
  // and pressed again (or its code changes).
  // ---------------------------------------------------------------------------
  logic [7:0] samp_ascii, prev_ascii;
  logic       samp_state, prev_state;
  logic       samp_vld, prev_vld;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      samp_ascii <= '0;
      samp_state <= 1'b0;
      samp_vld   <= 1'b0;
      prev_ascii <= '0;
      prev_state <= 1'b0;
      prev_vld   <= 1'b0;
    end else begin
      samp_ascii <= i_key_ascii;
      samp_state <= i_key_state;
      samp_vld   <= 1'b1;
      prev_ascii <= samp_ascii;
      prev_state <= samp_state;
      prev_vld   <= samp_vld;
    end
  end

  logic press_evt;
  assign press_evt = prev_vld && samp_state && (samp_ascii != 8'h00) &&
                     (!prev_state || (samp_ascii != prev_ascii));

  // ---------------------------------------------------------------------------
  // Auto-repeat FSM and timer
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          repeat_evt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    repeat_evt = 1'b0;
    if (!samp_state) begin
      // Release wins over everything, including a repeat due this cycle.
      state_d = IDLE;
      timer_d = '0;
    end else if (press_evt) begin
      // A new press (or code change) restarts the delay from scratch.
      state_d = DELAY;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = '0;
        end
        DELAY: begin
          if (timer_q == DELAY_LAST) begin
            state_d    = REPEAT;
            timer_d    = '0;
            repeat_evt = (samp_ascii != 8'h00);
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        REPEAT: begin
          if (timer_q == RATE_LAST) begin
            timer_d    = '0;
            repeat_evt = (samp_ascii != 8'h00);
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  logic       push_evt;
  logic [7:0] push_data;
  assign push_evt  = press_evt | repeat_evt;
  assign push_data = samp_ascii;

  // ---------------------------------------------------------------------------
  // Event FIFO (show-ahead). Pointers wrap naturally since DEPTH is 2**AW.
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          empty, full, do_pop, do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = i_rd_en && !empty;
  // When full, a push still goes through if a slot is being freed this cycle.
  assign do_push = push_evt && (!full || do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push_evt && !do_push) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign o_key      = empty ? 8'h00 : mem[rd_ptr];
  assign o_valid    = !empty;
  assign o_full     = full;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed testbench for key_event_queue with DEPTH=4, REPEAT_DELAY=10,
// REPEAT_RATE=4. Inputs change 1 time unit after a rising edge; outputs are
// checked 1 time unit after a rising edge.
module tb_key_event_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]    key_ascii;
  logic          key_state;
  logic          rd_en;
  logic [7:0]    key;
  logic          valid;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;

  key_event_queue #(
    .DEPTH(DEPTH),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_key_ascii(key_ascii),
    .i_key_state(key_state),
    .i_rd_en(rd_en),
    .o_key(key),
    .o_valid(valid),
    .o_full(full),
    .o_count(count),
    .o_overflow(overflow)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_key;
  int exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key"},   32'(key),      32'h0);
    check({tag, "_valid"}, 32'(valid),    32'h0);
    check({tag, "_full"},  32'(full),     32'h0);
    check({tag, "_count"}, 32'(count),    32'h0);
    check({tag, "_ovf"},   32'(overflow), 32'h0);
  endtask

  // Pop every entry in exp_q, checking head-of-queue order on the way.
  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      exp_key = exp_q.pop_front();
      check({tag, "_head"}, 32'(key), 32'(exp_key));
      rd_en = 1'b1;
      step_n(1);
      rd_en = 1'b0;
    end
    check({tag, "_empty_count"}, 32'(count), 32'h0);
    check({tag, "_empty_valid"}, 32'(valid), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    key_ascii = 8'h00;
    key_state = 1'b0;
    rd_en = 1'b0;
    #1;
    check_all_zero("reset");
    step_n(2);
    rst = 1'b0;
    step_n(3);

    // Basic press: visible one edge after the sampling edge, then popped.
    key_ascii = 8'h41;
    key_state = 1'b1;
    step_n(1);
    check("press_not_yet", 32'(valid), 32'h0);
    step_n(1);
    check("press_valid", 32'(valid), 32'h1);
    check("press_key",   32'(key),   32'h41);
    check("press_count", 32'(count), 32'h1);
    key_state = 1'b0;
    rd_en = 1'b1;
    step_n(1);
    rd_en = 1'b0;
    check("pop_valid", 32'(valid), 32'h0);
    check("pop_key",   32'(key),   32'h0);
    step_n(3);
    check("release_no_repeat", 32'(count), 32'h0);

    // Hold 0x41 for 30 cycles: pushes after steps 2, 12, 16, 20; drop at 24.
    key_ascii = 8'h41;
    key_state = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      step_n(1);
      exp_cnt = int'(n >= 2) + int'(n >= 12) + int'(n >= 16) + int'(n >= 20);
      check($sformatf("hold_count_%0d", n), 32'(count), 32'(exp_cnt));
      check($sformatf("hold_full_%0d", n), 32'(full), 32'(exp_cnt == 4));
      check($sformatf("hold_ovf_%0d", n), 32'(overflow), 32'(n >= 24));
    end
    key_state = 1'b0;
    step_n(4);
    check("hold_release_count", 32'(count), 32'h4);
    check("hold_release_key",   32'(key),   32'h41);

    // Full queue: push of 0x43 coincides with a pop.
    key_ascii = 8'h43;
    key_state = 1'b1;
    step_n(1);
    rd_en = 1'b1;
    key_state = 1'b0;
    step_n(1);
    rd_en = 1'b0;
    check("fullpp_count", 32'(count),    32'h4);
    check("fullpp_full",  32'(full),     32'h1);
    check("fullpp_ovf",   32'(overflow), 32'h1);
    exp_q = '{8'h41, 8'h41, 8'h41, 8'h43};
    drain("fullpp");
    check("fullpp_ovf_sticky", 32'(overflow), 32'h1);

    // Empty queue: push and i_rd_en in the same cycle keep the push.
    key_ascii = 8'h44;
    key_state = 1'b1;
    step_n(1);
    rd_en = 1'b1;
    key_state = 1'b0;
    step_n(1);
    rd_en = 1'b0;
    check("emptypp_count", 32'(count), 32'h1);
    check("emptypp_key",   32'(key),   32'h44);
    exp_q = '{8'h44};
    drain("emptypp");

    // Code change while held: second press restarts the repeat delay.
    key_ascii = 8'h41;
    key_state = 1'b1;
    step_n(3);
    key_ascii = 8'h42;
    step_n(2);
    check("change_count", 32'(count), 32'h2);
    check("change_key",   32'(key),   32'h41);
    step_n(7);
    check("change_no_old_repeat", 32'(count), 32'h2);
    step_n(2);
    check("change_before_repeat", 32'(count), 32'h2);
    step_n(1);
    check("change_repeat", 32'(count), 32'h3);
    key_state = 1'b0;
    step_n(1);
    exp_q = '{8'h41, 8'h42, 8'h42};
    drain("change");

    // ASCII 0x00 held plus reads on an empty queue: nothing happens.
    key_ascii = 8'h00;
    key_state = 1'b1;
    rd_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step_n(1);
      check($sformatf("null_count_%0d", n), 32'(count), 32'h0);
      check($sformatf("null_valid_%0d", n), 32'(valid), 32'h0);
      check($sformatf("null_key_%0d", n),   32'(key),   32'h0);
    end
    rd_en = 1'b0;
    key_state = 1'b0;
    step_n(2);

    // Three entries queued, reset mid-DELAY with the key still held.
    key_ascii = 8'h41;
    key_state = 1'b1;
    step_n(2);
    key_ascii = 8'h42;
    step_n(2);
    key_ascii = 8'h43;
    step_n(2);
    check("pre_rst_count", 32'(count), 32'h3);
    check("pre_rst_key",   32'(key),   32'h41);
    step_n(2);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    step_n(2);
    rst = 1'b0;
    for (int n = 0; n < 15; n++) begin
      step_n(1);
      check($sformatf("post_rst_count_%0d", n), 32'(count), 32'h0);
    end
    key_state = 1'b0;
    step_n(2);
    key_state = 1'b1;
    step_n(2);
    check("repress_count", 32'(count), 32'h1);
    check("repress_key",   32'(key),   32'h43);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
